forwarder_mp: RTL and testbench

Parametrised multi-port frame forwarder, the successor of the fixed 4-port forwarder. It takes 9-bit frame words from one ingress RX FIFO and extracts the 96-bit {eth_dst, eth_src} tuple. It then runs a held request/acknowledge lookup with timeout, buffering the frame internally meanwhile. Finally it replicates the frame to an NPORT-wide set of TX FIFOs under per-port backpressure, or drops it. One block sits behind each switch port, between the RX FIFO and the TX FIFO fabric.

---
 rtl/forwarder_mp.sv | 150 +++++++++++++++
 tb/tb_forwarder_mp.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/forwarder_mp.sv
// forwarder_mp: single-ingress frame forwarder. Pulls 9-bit words from the RX
// FIFO into a circular buffer, captures the {dst,src} tuple, runs a held
// req/ack lookup with timeout, then replicates the frame to the selected TX
// ports (all-or-nothing per word) or drains it silently.
// Optional build macro: FWD_HAIRPIN_EN (allow forwarding back out PORT_NUM).
module forwarder_mp #(
    parameter int NPORT     = 4,
    parameter int PORT_NUM  = 0,
    parameter int DEPTH     = 64,
    parameter int LOOKUP_TO = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [8:0]       rx_dout,
    input  logic             rx_empty,
    output logic             rx_rd_en,
    output logic [8:0]       tx_din,
    output logic [NPORT-1:0] tx_wr_en,
    input  logic [NPORT-1:0] tx_full,
    output logic             lookup_req,
    output logic [95:0]      lookup_tuple,
    input  logic             lookup_ack,
    input  logic [NPORT-1:0] lookup_fwd_port
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, LOOKUP, FWD, DROP} state_t;
    state_t state, state_nx;

    logic [8:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [AW+1:0]    fill;
    logic             eof_seen, rd_pending;
    logic [3:0]       byte_idx;   // header bytes captured so far, saturates at 12
    logic [3:0]       widx;       // header index of the word being pushed now
    logic [6:0]       tpos;
    logic [15:0]      to_cnt;
    logic [NPORT-1:0] mask, ack_mask;
    logic [8:0]       pop_word;
    logic             push, pop, word_term, pop_term, tx_stall;

    // The read in flight counts against free space so a full buffer never overflows.
    assign fill     = {1'b0, count} + (AW+2)'(rd_pending);
    assign rx_rd_en = sys_rst_n && !rx_empty && !eof_seen && !(rd_pending && !rx_dout[8])
                      && (fill < (AW+2)'(DEPTH));

    // Gap words are only kept once a frame is open; the opening byte is byte 0.
    assign push      = rd_pending && (state != IDLE || rx_dout[8]);
    assign word_term = push && !rx_dout[8];
    assign pop_word  = mem[rd_ptr];
    assign pop_term  = !pop_word[8];
    assign tx_stall  = |(tx_full & mask);
    assign widx      = (state == IDLE) ? 4'd0 : byte_idx;
    assign tpos      = 7'd88 - {widx, 3'b000};

`ifdef FWD_HAIRPIN_EN
    assign ack_mask = lookup_fwd_port;
`else
    assign ack_mask = lookup_fwd_port & ~(NPORT'(1) << PORT_NUM);
`endif

    // FSM state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nx;
    end

    // FSM next-state: header collect, lookup with timeout, then forward or drain
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (push) state_nx = HDR;
            HDR:    if (word_term) state_nx = DROP;
                    else if (push && byte_idx == 4'd11) state_nx = LOOKUP;
            LOOKUP: if (lookup_ack) state_nx = (ack_mask != '0) ? FWD : DROP;
                    else if (to_cnt == 16'(LOOKUP_TO - 1)) state_nx = DROP;
            FWD,
            DROP:   if (pop && pop_term) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: lookup request and buffer pop
    always_comb begin
        lookup_req = (state == LOOKUP);
        pop        = 1'b0;
        if (state == FWD)  pop = (count != '0) && !tx_stall;
        if (state == DROP) pop = (count != '0);
    end

    // Buffer storage; contents need no reset, occupancy is tracked by count
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= rx_dout;
    end

    // Buffer pointers, occupancy, read-pending and end-of-frame tracking
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_pending <= 1'b0;
            eof_seen   <= 1'b0;
        end else begin
            rd_pending <= rx_rd_en;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (pop && pop_term)   eof_seen <= 1'b0;
            else if (word_term)    eof_seen <= 1'b1;
        end
    end

    // Header capture: bytes 0..11 fill the tuple MSB first, then it holds
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_idx     <= '0;
            lookup_tuple <= '0;
        end else if (push) begin
            if (widx < 4'd12) lookup_tuple[tpos +: 8] <= rx_dout[7:0];
            byte_idx <= (widx == 4'd12) ? 4'd12 : widx + 4'd1;
        end
    end

    // Lookup timeout counter and destination mask latch
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            to_cnt <= '0;
            mask   <= '0;
        end else begin
            to_cnt <= (state == LOOKUP) ? to_cnt + 16'd1 : 16'd0;
            if (state == LOOKUP && lookup_ack) mask <= ack_mask;
        end
    end

    // TX write port: every selected port gets the popped word in the same cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_din   <= '0;
            tx_wr_en <= '0;
        end else if (pop && state == FWD) begin
            tx_din   <= pop_word;
            tx_wr_en <= mask;
        end else begin
            tx_wr_en <= '0;
        end
    end
endmodule

// File: tb/tb_forwarder_mp.sv
// tb_forwarder_mp: directed + randomized frames against a queue-based model of
// the RX FIFO, lookup responder and per-port expected TX streams.
module tb_forwarder_mp;
    localparam int NPORT = 4, PORT_NUM = 0, DEPTH = 16, LOOKUP_TO = 10;

    logic             sys_clk = 1'b0, sys_rst_n = 1'b0;
    logic [8:0]       rx_dout = '0;
    logic             rx_empty = 1'b0;
    logic             rx_rd_en;
    logic [8:0]       tx_din;
    logic [NPORT-1:0] tx_wr_en;
    logic [NPORT-1:0] tx_full = '0;
    logic             lookup_req;
    logic [95:0]      lookup_tuple;
    logic             lookup_ack = 1'b0;
    logic [NPORT-1:0] lookup_fwd_port = '0;

    always #5 sys_clk = ~sys_clk;

    forwarder_mp #(.NPORT(NPORT), .PORT_NUM(PORT_NUM), .DEPTH(DEPTH), .LOOKUP_TO(LOOKUP_TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .rx_dout(rx_dout), .rx_empty(rx_empty), .rx_rd_en(rx_rd_en),
        .tx_din(tx_din), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
        .lookup_req(lookup_req), .lookup_tuple(lookup_tuple),
        .lookup_ack(lookup_ack), .lookup_fwd_port(lookup_fwd_port)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    logic [8:0]       rxq[$];
    logic [8:0]       got[NPORT][$];
    logic [8:0]       expq[NPORT][$];
    logic [NPORT-1:0] prev_full = '0, cur_mask = '0, cfg_fwd = '0;
    logic [95:0]      tup_s, exp_tup;
    logic             rd_s;
    int req_cycles, req_run = 0, ack_dly = 0, full_mode = 0, stall_en = 0;
    int ack_cyc, first_wr_cyc, wr_total, exp_req, f_len;
    bit fwd_ok;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at negedge, drive environment #1 after posedge.
    task automatic step();
        @(negedge sys_clk);
        rd_s = rx_rd_en;
        if (tx_wr_en != '0) begin
            chk("wr_mask", tx_wr_en, cur_mask);
            chk("wr_while_full", tx_wr_en & prev_full, 0);
            if (wr_total == 0) first_wr_cyc = cyc;
            wr_total++;
            for (int p = 0; p < NPORT; p++) if (tx_wr_en[p]) got[p].push_back(tx_din);
        end
        prev_full = tx_full;
        if (lookup_req) begin
            req_cycles++;
            tup_s = lookup_tuple;
        end
        @(posedge sys_clk);
        #1;
        cyc++;
        if (rd_s) rx_dout = rxq.pop_front();
        rx_empty = (rxq.size() == 0) || (stall_en != 0 && $urandom_range(3) == 0);
        case (full_mode)
            1:       tx_full = (((cyc / 3) % 2) != 0) ? 4'b0010 : 4'b0000;
            2:       tx_full = NPORT'($urandom_range(15)) & NPORT'($urandom_range(15));
            default: tx_full = '0;
        endcase
        lookup_ack = 1'b0;
        lookup_fwd_port = NPORT'($urandom_range(15));
        if (lookup_req) begin
            req_run++;
            if (ack_dly != 0 && req_run == ack_dly) begin
                lookup_ack = 1'b1;
                lookup_fwd_port = cfg_fwd;
                ack_cyc = cyc;
            end
        end else begin
            req_run = 0;
        end
    endtask

    // Build one frame into the RX FIFO and the expected per-port streams.
    task automatic build(input int len, input logic [95:0] hdr, input logic [NPORT-1:0] fwd,
                         input int adly, input int fmode, input int stl);
        logic [NPORT-1:0] m;
        logic [8:0] w;
        int ng;
        ng = $urandom_range(2);
        for (int g = 0; g < ng; g++) rxq.push_back({1'b0, 8'($urandom)});
        for (int p = 0; p < NPORT; p++) begin
            expq[p].delete();
            got[p].delete();
        end
        m = fwd;
`ifndef FWD_HAIRPIN_EN
        m[PORT_NUM] = 1'b0;
`endif
        fwd_ok   = (len >= 12) && (adly != 0) && (m != '0);
        cur_mask = fwd_ok ? m : '0;
        exp_req  = (len < 12) ? 0 : ((adly == 0) ? LOOKUP_TO : adly);
        exp_tup  = hdr;
        f_len    = len;
        for (int i = 0; i <= len; i++) begin
            if (i == len) w = {1'b0, 8'($urandom)};
            else          w = {1'b1, (i < 12) ? hdr[95 - 8*i -: 8] : 8'($urandom)};
            rxq.push_back(w);
            for (int p = 0; p < NPORT; p++) if (cur_mask[p]) expq[p].push_back(w);
        end
        cfg_fwd = fwd; ack_dly = adly; full_mode = fmode; stall_en = stl;
        req_cycles = 0; wr_total = 0; ack_cyc = -1; first_wr_cyc = -1; tup_s = '0;
    endtask

    task automatic run_check(input string name);
        int budget, quiet, bad;
        budget = 0; quiet = 0;
        while ((rxq.size() != 0 || quiet < 40) && budget < 3000) begin
            step();
            budget++;
            if (rxq.size() == 0 && tx_wr_en == '0 && !lookup_req) quiet++;
            else quiet = 0;
        end
        chk({name, " completes"}, budget < 3000, 1);
        chk({name, " req_cycles"}, req_cycles, exp_req);
        if (f_len >= 12) chk({name, " tuple"}, tup_s, exp_tup);
        for (int p = 0; p < NPORT; p++) begin
            chk($sformatf("%s p%0d words", name, p), got[p].size(), expq[p].size());
            if (got[p].size() == expq[p].size()) begin
                bad = 0;
                foreach (got[p][i]) if (got[p][i] !== expq[p][i]) bad++;
                if (expq[p].size() != 0) chk($sformatf("%s p%0d data_errs", name, p), bad, 0);
            end
        end
        if (fwd_ok && full_mode == 0) chk({name, " ack_to_wr"}, first_wr_cyc - ack_cyc, 2);
        full_mode = 0; stall_en = 0;
    endtask

    initial begin
        int tot, n;
        // reset state, with data waiting in the RX FIFO
        rx_dout = 9'h1AA;
        rx_empty = 1'b0;
        #12;
        chk("rst rx_rd_en", rx_rd_en, 0);
        chk("rst lookup_req", lookup_req, 0);
        chk("rst tx_wr_en", tx_wr_en, 0);
        chk("rst tx_din", tx_din, 0);
        chk("rst tuple", lookup_tuple, 0);
        rx_empty = 1'b1;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        build(64, 96'h020000000001_020000000002, 4'b0110, 5, 0, 0);
        run_check("basic64");

        build(8, {3{$urandom}}, 4'b1110, 3, 0, 0);
        run_check("runt8");

        build(30, {3{$urandom}}, 4'b1110, 0, 0, 1);
        run_check("noack");
        build(40, {3{$urandom}}, 4'b1000, 3, 0, 1);
        run_check("after_to");

        build(40, {3{$urandom}}, 4'b0001, 4, 0, 0);
        run_check("hairpin");

        build(200, {3{$urandom}}, 4'b1011, 2, 1, 0);
        run_check("long200");

        for (int k = 0; k < 5; k++) begin
            build($urandom_range(1, 80), {3{$urandom}}, NPORT'($urandom_range(15)),
                  $urandom_range(0, 9), $urandom_range(0, 2), $urandom_range(1));
            run_check($sformatf("rand%0d", k));
        end

        // reset in the middle of a frame
        build(100, {3{$urandom}}, 4'b0110, 2, 0, 0);
        tot = rxq.size();
        n = 0;
        while (tot - rxq.size() < 31 && n < 500) begin
            step();
            n++;
        end
        chk("midrst reached byte30", n < 500, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst rx_rd_en", rx_rd_en, 0);
        chk("midrst tx_wr_en", tx_wr_en, 0);
        chk("midrst tx_din", tx_din, 0);
        chk("midrst lookup_req", lookup_req, 0);
        chk("midrst tuple", lookup_tuple, 0);
        rxq.delete();
        rx_empty = 1'b1; lookup_ack = 1'b0; req_run = 0; tx_full = '0; prev_full = '0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("post_rst tx_wr_en", tx_wr_en, 0);
        chk("post_rst lookup_req", lookup_req, 0);
        chk("post_rst tx_din", tx_din, 0);
        @(posedge sys_clk);
        #1;
        build(50, {3{$urandom}}, 4'b0110, 4, 0, 0);
        run_check("post_rst_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
